// File: rtl/mult8x8_seq.sv
// mult8x8_seq: sequential 8x8 unsigned multiplier accumulating four 4x4 partial products.
module mult8x8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [15:0] product,
  output logic        done,
  output logic [2:0]  state_out
);
  typedef enum logic [2:0] {IDLE = 3'b000, LSB = 3'b001, MID = 3'b010, MSB = 3'b011, ERR = 3'b100} state_t;
  state_t      r_state;
  logic [7:0]  r_a, r_b;
  logic [15:0] r_acc;
  logic [1:0]  r_cnt;
  logic        r_done;
  logic [3:0]  w_x, w_y;
  logic [7:0]  w_pp;
  logic [1:0]  w_sh;
  logic [15:0] w_term;
  // cnt bit 0 picks the multiplicand nibble, bit 1 the multiplier nibble
  assign w_x       = r_cnt[0] ? r_a[7:4] : r_a[3:0];
  assign w_y       = r_cnt[1] ? r_b[7:4] : r_b[3:0];
  assign w_pp      = w_x * w_y;
  assign w_sh      = {r_cnt[1] & r_cnt[0], r_cnt[1] ^ r_cnt[0]};
  assign w_term    = {8'b0, w_pp} << {w_sh, 2'b00};
  assign product   = r_acc;
  assign done      = r_done;
  assign state_out = r_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= dataa;
          r_b     <= datab;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_done  <= 1'b0;
          r_state <= LSB;
        end
        LSB, MID, MSB: if (start) begin
          r_acc   <= '0;
          r_cnt   <= '0;
          r_done  <= 1'b0;
          r_state <= ERR;
        end else begin
          r_acc   <= r_acc + w_term;
          r_cnt   <= r_cnt + 2'd1;
          r_done  <= r_state == MSB;
          r_state <= r_state == LSB ? MID : r_state == MSB ? IDLE : (r_cnt == 2'd1 ? MID : MSB);
        end
        ERR: r_state <= start ? ERR : IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mult8x8_seq.sv
// tb_mult8x8_seq: randomized and directed checks of mult8x8_seq against a*b and the step sequence.
module tb_mult8x8_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  dataa, datab;
  logic [15:0] product;
  logic        done;
  logic [2:0]  state_out;
  int          n_vec = 0;
  int          n_err = 0;

  mult8x8_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dataa(dataa), .datab(datab),
    .product(product), .done(done), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiply from accept edge to completion; optional operand change after accept
  task automatic mul(input logic [7:0] a, input logic [7:0] b, input bit chg,
                     input logic [7:0] ca, input logic [7:0] cb);
    logic [15:0] exp;
    exp = 16'(a) * 16'(b);
    dataa = a;
    datab = b;
    start = 1'b1;
    tick();
    check("accept_state", 16'(state_out), 16'd1);
    check("accept_done", 16'(done), 16'd0);
    start = 1'b0;
    if (chg) begin
      dataa = ca;
      datab = cb;
    end
    tick();
    check("e1_state", 16'(state_out), 16'd2);
    tick();
    check("e2_state", 16'(state_out), 16'd2);
    tick();
    check("e3_state", 16'(state_out), 16'd3);
    check("e3_done", 16'(done), 16'd0);
    tick();
    check("e4_state", 16'(state_out), 16'd0);
    check("e4_done", 16'(done), 16'd1);
    check("product", product, exp);
  endtask

  task automatic idle_hold(input logic [15:0] exp);
    start = 1'b0;
    dataa = 8'($urandom);
    datab = 8'($urandom);
    tick();
    check("hold_state", 16'(state_out), 16'd0);
    check("hold_done", 16'(done), 16'd1);
    check("hold_product", product, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dataa = 8'h00;
    datab = 8'h00;
    #3;
    check("rst_state", 16'(state_out), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_product", product, 16'd0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_state", 16'(state_out), 16'd0);
    check("post_rst_done", 16'(done), 16'd0);

    mul(8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00);
    idle_hold(16'hFE01);
    mul(8'h12, 8'h34, 1'b0, 8'h00, 8'h00);
    idle_hold(16'h03A8);
    mul(8'h00, 8'hAB, 1'b0, 8'h00, 8'h00);
    idle_hold(16'h0000);
    mul(8'h01, 8'hFF, 1'b0, 8'h00, 8'h00);

    // back-to-back: second start presented right when IDLE is reached
    mul(8'h0F, 8'hF0, 1'b0, 8'h00, 8'h00);
    mul(8'h80, 8'h02, 1'b0, 8'h00, 8'h00);

    mul(8'h10, 8'h10, 1'b1, 8'hFF, 8'hFF);

    // abort during MID
    dataa = 8'h55;
    datab = 8'h66;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_abort_state", 16'(state_out), 16'd2);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_state", 16'(state_out), 16'd4);
      check("abort_done", 16'(done), 16'd0);
      check("abort_product", product, 16'd0);
    end
    start = 1'b0;
    tick();
    check("abort_exit_state", 16'(state_out), 16'd0);
    check("abort_exit_done", 16'(done), 16'd0);
    check("abort_exit_product", product, 16'd0);
    tick();
    check("abort_idle_done", 16'(done), 16'd0);
    check("abort_idle_product", product, 16'd0);

    // asynchronous reset while in MSB
    dataa = 8'hFF;
    datab = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_areset_state", 16'(state_out), 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_state", 16'(state_out), 16'd0);
    check("areset_product", product, 16'd0);
    check("areset_done", 16'(done), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("after_areset_state", 16'(state_out), 16'd0);
      check("after_areset_done", 16'(done), 16'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      mul(a, b, 1'($urandom), 8'($urandom), 8'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) idle_hold(16'(a) * 16'(b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
